moving_average_inverse: RTL
===========================

Name: moving_average_inverse

Overview:
- Reconstructs the original sample stream from the running-sum output of the moving-average filter (decoder for the filter's encoder).
- Recurrence: x[n] = s[n] - s[n-1] + x[n-W], where s is the W-sample running sum and history before the first accepted sum is zero.
- Sits downstream of the moving-average filter in loopback/self-check paths; also serves as the bench reference checker.

Parameters:
SIZE_MAX_WINDOW, 64, maximum window depth; sets history buffer depth
SIZE_WINDOW, 8, window length loaded at reset
SIZE_DATA, 16, width of reconstructed signed samples
SIZE_SUM, SIZE_DATA+$clog2(SIZE_MAX_WINDOW) (22), width of incoming signed running sum

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
clear  in  1  synchronous restart; empties history, latches window_size
window_size  in  $clog2(SIZE_MAX_WINDOW)+1 (7)  requested window W, legal 1..SIZE_MAX_WINDOW
sum_valid  in  1  sum_data valid this cycle
sum_data  in  SIZE_SUM  signed running sum s[n]
out_valid  out  1  out_data valid
out_data  out  SIZE_DATA  signed reconstructed sample x[n]
window_error  out  1  sticky: illegal window_size seen at clear

Behaviour:
- Reset (reset_n=0, async): out_valid=0, out_data=0, window_error=0, W=SIZE_WINDOW, prev_sum=0, wr_ptr=0, fill=0. History RAM contents are not reset; the fill counter masks them.
- Datapath: one-cycle latency. When sum_valid=1 at edge k, out_valid=1 and out_data=x[n] at edge k+1. out_valid is otherwise 0 and out_data holds its last value.
- No backpressure; one sample accepted per cycle, every cycle if required.
- History buffer:
  - SIZE_MAX_WINDOW entries of SIZE_DATA, circular.
  - wr_ptr wraps SIZE_MAX_WINDOW-1 -> 0.
  - old = buf[(wr_ptr - W) mod SIZE_MAX_WINDOW] when fill >= W, else 0.
  - On accept: buf[wr_ptr] <= x[n]; wr_ptr++.
  - fill increments, saturating at SIZE_MAX_WINDOW.
- Arithmetic:
  - d = sum_data - prev_sum, computed modulo 2^SIZE_SUM.
  - x = d + sign-extended old, computed modulo 2^SIZE_SUM.
  - out_data = x[SIZE_DATA-1:0], which is exact for any legal upstream stream.
  - prev_sum <= sum_data on accept.
- Read/write same cycle: read uses the pre-write contents. When W = SIZE_MAX_WINDOW, the read address equals wr_ptr; the old value must be returned, not the new write.
- clear=1:
  - Next cycle: prev_sum=0, fill=0, wr_ptr=0, out_valid=0.
  - If window_size is in 1..SIZE_MAX_WINDOW, W <= window_size.
  - Otherwise W is unchanged and window_error <= 1.
  - clear has priority over a simultaneous sum_valid; that sample is dropped, with no output.
- window_error clears only on reset_n.
- W changes only at clear or reset. window_size is ignored at all other times.
- Reset mid-stream aborts any pending output; out_valid=0 immediately (async).

Test Plan:
- Constant step, W=8, x=100: sums 100,200,...,800 then 800 repeated for 20 samples -> out_data = 100 on all 28 outputs, each one cycle after its sum_valid.
- Ramp, W=8, x[n]=n for n=1..40 fed as correct running sums -> out_data = 1..40 in order, including across wr_ptr wrap at 64 (extend to 100 samples).
- W=64 via clear with window_size=64, random signed samples incl. -32768 and 32767, 200 samples back-to-back -> exact reconstruction; exercises read==write address.
- clear with window_size=0, then 65 -> window_error=1 after the first; W stays 8; constant-step test still passes after each clear.
- clear asserted together with sum_valid mid-stream -> no out_valid next cycle; the following stream (restarted from zero history, sums 50,100,...) reconstructs 50s.
- reset_n pulsed low for half a cycle mid-stream -> out_valid=0 immediately, W=8, subsequent fresh stream reconstructs exactly.

Source files
------------

// File: rtl/moving_average_inverse.sv
// Moving-average inverse: rebuilds the sample stream x[n] from the running sum
// s[n] of a W-tap moving-average filter, x[n] = s[n] - s[n-1] + x[n-W].
module moving_average_inverse #(
  parameter int unsigned SIZE_MAX_WINDOW = 64,
  parameter int unsigned SIZE_WINDOW     = 8,
  parameter int unsigned SIZE_DATA       = 16,
  parameter int unsigned SIZE_SUM        = SIZE_DATA + $clog2(SIZE_MAX_WINDOW)
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              clear,
  input  logic [$clog2(SIZE_MAX_WINDOW):0]  window_size,
  input  logic                              sum_valid,
  input  logic [SIZE_SUM-1:0]               sum_data,
  output logic                              out_valid,
  output logic [SIZE_DATA-1:0]              out_data,
  output logic                              window_error
);

  localparam int unsigned AW  = $clog2(SIZE_MAX_WINDOW);
  localparam int unsigned WW  = AW + 1;
  localparam int unsigned EXT = SIZE_SUM - SIZE_DATA;

  logic [WW-1:0]        w_q, w_d;
  logic [SIZE_SUM-1:0]  prev_sum_q, prev_sum_d;
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [WW-1:0]        fill_q, fill_d;
  logic                 out_valid_q, out_valid_d;
  logic [SIZE_DATA-1:0] out_data_q, out_data_d;
  logic                 window_error_q, window_error_d;

  logic [SIZE_DATA-1:0] hist_mem [SIZE_MAX_WINDOW];

  logic [AW-1:0]        rd_addr_c;
  logic [SIZE_DATA-1:0] old_c;
  logic [SIZE_SUM-1:0]  diff_c;
  logic [SIZE_SUM-1:0]  x_c;
  logic                 wr_en_c;
  logic                 win_legal_c;
  logic                 unused_x_hi_c;

  // Only the low SIZE_DATA bits of the wide reconstruction are meaningful
  assign unused_x_hi_c = ^x_c[SIZE_SUM-1:SIZE_DATA];

  // Reconstruction datapath and next-state logic; clear wins over sum_valid
  always_comb begin
    w_d            = w_q;
    prev_sum_d     = prev_sum_q;
    wr_ptr_d       = wr_ptr_q;
    fill_d         = fill_q;
    out_valid_d    = 1'b0;
    out_data_d     = out_data_q;
    window_error_d = window_error_q;
    wr_en_c        = 1'b0;

    // With W = SIZE_MAX_WINDOW the read address aliases wr_ptr; the
    // combinational read still sees the pre-write entry
    rd_addr_c   = wr_ptr_q - w_q[AW-1:0];
    old_c       = (fill_q >= w_q) ? hist_mem[rd_addr_c] : '0;
    diff_c      = sum_data - prev_sum_q;
    x_c         = diff_c + {{EXT{old_c[SIZE_DATA-1]}}, old_c};
    win_legal_c = (window_size != '0) && (window_size <= WW'(SIZE_MAX_WINDOW));

    if (clear) begin
      prev_sum_d = '0;
      fill_d     = '0;
      wr_ptr_d   = '0;
      if (win_legal_c) begin
        w_d = window_size;
      end else begin
        window_error_d = 1'b1;
      end
    end else if (sum_valid) begin
      out_valid_d = 1'b1;
      out_data_d  = x_c[SIZE_DATA-1:0];
      prev_sum_d  = sum_data;
      wr_ptr_d    = wr_ptr_q + AW'(1);
      wr_en_c     = 1'b1;
      if (fill_q != WW'(SIZE_MAX_WINDOW)) begin
        fill_d = fill_q + WW'(1);
      end
    end
  end

  // Control and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      w_q            <= WW'(SIZE_WINDOW);
      prev_sum_q     <= '0;
      wr_ptr_q       <= '0;
      fill_q         <= '0;
      out_valid_q    <= 1'b0;
      out_data_q     <= '0;
      window_error_q <= 1'b0;
    end else begin
      w_q            <= w_d;
      prev_sum_q     <= prev_sum_d;
      wr_ptr_q       <= wr_ptr_d;
      fill_q         <= fill_d;
      out_valid_q    <= out_valid_d;
      out_data_q     <= out_data_d;
      window_error_q <= window_error_d;
    end
  end

  // History buffer; contents are masked by fill_q rather than reset
  always_ff @(posedge clk) begin
    if (wr_en_c) begin
      hist_mem[wr_ptr_q] <= x_c[SIZE_DATA-1:0];
    end
  end

  assign out_valid    = out_valid_q;
  assign out_data     = out_data_q;
  assign window_error = window_error_q;

endmodule
